// File: rtl/lab_readout_seq_if.sv
// lab_readout_seq_if: LAB pin bus plus the event-buffer write port of the readout sequencer.
// Latency: none; this is a plain signal bundle.
// Backpressure: none; the event RAM accepts every wr_o strobe.
// Ports (signals):
//   SELMAIN/SELTAIL/CS/S : cell select toward the LAB (driven by master)
//   DAT/RCO/HITBUS       : LAB returns (driven by slave)
//   addr_o/dat_o/wr_o    : write strobe toward the event buffer (driven by master)
interface lab_readout_seq_if #(
  parameter int CS_WIDTH   = 4,
  parameter int S_WIDTH    = 8,
  parameter int DAT_WIDTH  = 12,
  parameter int ADDR_WIDTH = 12
);
  logic                  SELMAIN;
  logic                  SELTAIL;
  logic [CS_WIDTH-1:0]   CS;
  logic [S_WIDTH-1:0]    S;
  logic [DAT_WIDTH-1:0]  DAT;
  logic                  RCO;
  logic                  HITBUS;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DAT_WIDTH+3:0]  dat_o;
  logic                  wr_o;

  modport master (
    output SELMAIN, SELTAIL, CS, S, addr_o, dat_o, wr_o,
    input  DAT, RCO, HITBUS
  );

  modport slave (
    input  SELMAIN, SELTAIL, CS, S, addr_o, dat_o, wr_o,
    output DAT, RCO, HITBUS
  );
endinterface

// File: rtl/lab_readout_seq.sv
// lab_readout_seq: walks every enabled LAB channel through its main and tail cells, emits tagged writes.
// Latency: busy 1 cycle after start; each write DAT_LATENCY cycles after its cell hits the pins.
// Backpressure: none; starts while busy (including the done cycle) are dropped, not queued.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   readout_i          : start pulse; ch_mask_i captured when it is accepted
//   hold_i             : closes the RCO latch while high
//   lab (master)       : LAB select pins, DAT/RCO/HITBUS returns, addr_o/dat_o/wr_o write port
//   hitbus_o, rco_o    : registered HITBUS, latched RCO
//   busy_o, done_o     : sequence in progress, one-cycle completion pulse
module lab_readout_seq #(
  parameter int NUM_CHANNELS     = 9,
  parameter int NUM_SAMPLES      = 256,
  parameter int NUM_TAIL_SAMPLES = 4,
  parameter int CS_WIDTH         = 4,
  parameter int S_WIDTH          = 8,
  parameter int DAT_WIDTH        = 12,
  parameter int ADDR_WIDTH       = 12,
  parameter int DAT_LATENCY      = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    readout_i,
  input  logic [NUM_CHANNELS-1:0] ch_mask_i,
  input  logic                    hold_i,
  lab_readout_seq_if.master       lab,
  output logic                    hitbus_o,
  output logic                    rco_o,
  output logic                    busy_o,
  output logic                    done_o
);
  localparam int SPC = NUM_SAMPLES + NUM_TAIL_SAMPLES;
  localparam int CW  = $clog2(SPC + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;

  // Lowest set bit of m at or above 'from'; MSB of the result flags "found".
  function automatic logic [CS_WIDTH:0] next_en(input logic [NUM_CHANNELS-1:0] m, input int from);
    logic [CS_WIDTH:0] r;
    r = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--)
      if (i >= from && m[i]) r = {1'b1, CS_WIDTH'(i)};
    return r;
  endfunction

  state_t                  state_q, state_d;
  logic [CS_WIDTH-1:0]     ch_q, ch_d;
  logic [CW-1:0]           cell_q, cell_d;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d;
  logic [2:0]              drn_q, drn_d;
  logic [CS_WIDTH:0]       first_en, next_ch;
  logic                    start;

  logic                    selmain_q, selmain_d, seltail_q, seltail_d;
  logic [CS_WIDTH-1:0]     cs_q, cs_d;
  logic [S_WIDTH-1:0]      s_q, s_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    pv_d;
  logic [ADDR_WIDTH-1:0]   pa_d;

  // Write pipeline: stage 0 lines up with the pin flops, wr_o follows the last stage.
  logic [DAT_LATENCY-1:0]  vld_q;
  logic [ADDR_WIDTH-1:0]   adr_q [DAT_LATENCY];
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   waddr_q;
  logic [DAT_WIDTH-1:0]    dat_q;
  logic                    hitbus_q;
  logic                    rco_lat;

  // busy_q is still high during the done cycle, which is what drops a coincident start.
  assign start = (state_q == IDLE) && readout_i && !busy_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ch_q    <= '0;
      cell_q  <= '0;
      mask_q  <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cell_q  <= cell_d;
      mask_q  <= mask_d;
      drn_q   <= drn_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cell_d   = cell_q;
    mask_d   = mask_q;
    drn_d    = drn_q;
    first_en = next_en(ch_mask_i, 0);
    next_ch  = next_en(mask_q, int'(ch_q) + 1);
    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d  = ch_mask_i;
          cell_d  = '0;
          ch_d    = first_en[CS_WIDTH-1:0];
          state_d = first_en[CS_WIDTH] ? SCAN : FINISH;
        end
      end
      SCAN: begin
        if (cell_q == CW'(SPC - 1)) begin
          cell_d = '0;
          if (next_ch[CS_WIDTH]) begin
            ch_d = next_ch[CS_WIDTH-1:0];
          end else begin
            state_d = DRAIN;
            drn_d   = '0;
          end
        end else begin
          cell_d = cell_q + CW'(1);
        end
      end
      DRAIN: begin
        if (drn_q == 3'(DAT_LATENCY - 1)) state_d = FINISH;
        else drn_d = drn_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values for the pin flops, status flops and write pipeline head
  always_comb begin
    selmain_d = 1'b0;
    seltail_d = 1'b0;
    cs_d      = cs_q;
    s_d       = s_q;
    pv_d      = 1'b0;
    pa_d      = ADDR_WIDTH'(ch_q) * ADDR_WIDTH'(SPC) + ADDR_WIDTH'(cell_q);
    done_d    = (state_q == FINISH);
    busy_d    = (state_q != IDLE) || start;
    if (state_q == SCAN) begin
      pv_d = 1'b1;
      cs_d = ch_q;
      if (cell_q < CW'(NUM_SAMPLES)) begin
        selmain_d = 1'b1;
        s_d       = S_WIDTH'(cell_q);
      end else begin
        seltail_d = 1'b1;
        s_d       = S_WIDTH'(cell_q - CW'(NUM_SAMPLES));
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      selmain_q <= 1'b0;
      seltail_q <= 1'b0;
      cs_q      <= '0;
      s_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      vld_q     <= '0;
      for (int i = 0; i < DAT_LATENCY; i++) adr_q[i] <= '0;
      wr_q      <= 1'b0;
      waddr_q   <= '0;
      dat_q     <= '0;
      hitbus_q  <= 1'b0;
    end else begin
      selmain_q <= selmain_d;
      seltail_q <= seltail_d;
      cs_q      <= cs_d;
      s_q       <= s_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      vld_q[0]  <= pv_d;
      adr_q[0]  <= pa_d;
      for (int i = 1; i < DAT_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        adr_q[i] <= adr_q[i-1];
      end
      wr_q <= vld_q[DAT_LATENCY-1];
      if (vld_q[DAT_LATENCY-1]) waddr_q <= adr_q[DAT_LATENCY-1];
      dat_q    <= lab.DAT;
      hitbus_q <= lab.HITBUS;
    end
  end

  // RCO is captured by a real transparent latch, deliberately outside reset.
  always_latch begin
    if (!hold_i) rco_lat <= lab.RCO;
  end

  assign lab.SELMAIN = selmain_q;
  assign lab.SELTAIL = seltail_q;
  assign lab.CS      = cs_q;
  assign lab.S       = s_q;
  assign lab.wr_o    = wr_q;
  assign lab.addr_o  = waddr_q;
  assign lab.dat_o   = {2'b00, rco_lat, hitbus_q, dat_q};
  assign hitbus_o    = hitbus_q;
  assign rco_o       = rco_lat;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
endmodule

// File: tb/tb_lab_readout_seq.sv
// tb_lab_readout_seq: random-data readout runs on a default DUT (A) and a DAT_LATENCY=3 DUT (B).
// Latency: LAB model returns DAT for a presented cell DAT_LATENCY edges after the pins show it.
// Backpressure: none.
`timescale 1ns/1ps
module tb_lab_readout_seq;
  localparam int NS = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, readout, hold, rco_in, hb_in, sel;
  logic [8:0] mask;
  logic [11:0] key;
  logic       readout_a, readout_b;
  logic       hb_a, hb_b, rco_a, rco_b, busy_a, busy_b, done_a, done_b;
  int         n_chk = 0, n_pass = 0;

  lab_readout_seq_if #(.CS_WIDTH(4), .S_WIDTH(8), .DAT_WIDTH(12), .ADDR_WIDTH(12)) ifa ();
  lab_readout_seq_if #(.CS_WIDTH(4), .S_WIDTH(8), .DAT_WIDTH(12), .ADDR_WIDTH(12)) ifb ();

  assign readout_a = readout & ~sel;
  assign readout_b = readout & sel;
  assign ifa.RCO = rco_in;
  assign ifb.RCO = rco_in;
  assign ifa.HITBUS = hb_in;
  assign ifb.HITBUS = hb_in;

  lab_readout_seq dut_a (
    .clk_i(clk), .rst_i(rst), .readout_i(readout_a), .ch_mask_i(mask), .hold_i(hold),
    .lab(ifa), .hitbus_o(hb_a), .rco_o(rco_a), .busy_o(busy_a), .done_o(done_a)
  );

  lab_readout_seq #(.NUM_CHANNELS(4), .NUM_TAIL_SAMPLES(8), .DAT_LATENCY(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .readout_i(readout_b), .ch_mask_i(mask[3:0]), .hold_i(hold),
    .lab(ifb), .hitbus_o(hb_b), .rco_o(rco_b), .busy_o(busy_b), .done_o(done_b)
  );

  // Observation mux onto the DUT under test
  wire        wr   = sel ? ifb.wr_o    : ifa.wr_o;
  wire [11:0] addr = sel ? ifb.addr_o  : ifa.addr_o;
  wire [15:0] dat  = sel ? ifb.dat_o   : ifa.dat_o;
  wire        selm = sel ? ifb.SELMAIN : ifa.SELMAIN;
  wire        selt = sel ? ifb.SELTAIL : ifa.SELTAIL;
  wire [7:0]  s    = sel ? ifb.S       : ifa.S;
  wire        busy = sel ? busy_b : busy_a;
  wire        done = sel ? done_b : done_a;
  wire        hbo  = sel ? hb_b   : hb_a;
  wire        rcoo = sel ? rco_b  : rco_a;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [11:0] pat(input int a);
    return 12'(a * 37 + 5) ^ 12'(a >> 3) ^ key;
  endfunction

  // Address of the cell currently shown on the pins, -1 when nothing is selected.
  function automatic int cell_id(input logic sm, input logic st, input logic [3:0] c,
                                 input logic [7:0] sv, input int spc);
    if (sm) return int'(c) * spc + int'(sv);
    if (st) return int'(c) * spc + NS + int'(sv);
    return -1;
  endfunction

  // LAB behaviour: history of presented cells, DAT = pattern of the cell from L-1 cycles ago.
  int hist_a[4], hist_b[4];
  always @(negedge clk) begin
    for (int i = 3; i > 0; i--) begin
      hist_a[i] = hist_a[i-1];
      hist_b[i] = hist_b[i-1];
    end
    hist_a[0] = cell_id(ifa.SELMAIN, ifa.SELTAIL, ifa.CS, ifa.S, NS + 4);
    hist_b[0] = cell_id(ifb.SELMAIN, ifb.SELTAIL, ifb.CS, ifb.S, NS + 8);
    ifa.DAT = (hist_a[0] < 0) ? 12'hA5A : pat(hist_a[0]);
    ifb.DAT = (hist_b[2] < 0) ? 12'hA5A : pat(hist_b[2]);
  end

  task automatic run(input logic b, input logic [8:0] m, input int rst_at, input int pulse_at,
                     input bit pulse_done, input int hold_at);
    int nc, nt, spc, q[$], k, wcnt, last_wr, done_k, ndone, ntail, nmain, exp_n, pop;
    bit pulsed, aborted;
    logic [11:0] ea;
    logic rco_ref, hb_prev;
    nc = b ? 4 : 9;
    nt = b ? 8 : 4;
    spc = NS + nt;
    pop = 0;
    for (int c = 0; c < nc; c++)
      if (m[c]) begin
        pop++;
        for (int i = 0; i < spc; i++) q.push_back(c * spc + i);
      end
    exp_n = q.size();
    @(negedge clk);
    key = 12'($urandom);
    sel = b;
    mask = m;
    readout = 1'b1;
    hb_prev = hb_in;
    rco_ref = rco_in;
    k = 0; wcnt = 0; last_wr = -1; done_k = -1; ndone = 0; ntail = 0; nmain = 0;
    pulsed = 0; aborted = 0;
    while (1) begin
      @(negedge clk);
      k++;
      readout = 1'b0;
      if (k > exp_n + 40) begin
        chk("timeout", k, exp_n + 40);
        break;
      end
      if (k == 1) chk("busy_rise", busy, 1);
      chk("hitbus_o", hbo, hb_prev);
      chk("rco_o", rcoo, rco_ref);
      chk("sel_excl", selm & selt, 0);
      if (selm) nmain++;
      if (selt) begin
        ntail++;
        chk("tail_s", int'(s) < nt, 1);
      end
      if (wr) begin
        if (q.size() == 0) chk("wr_over", wcnt + 1, exp_n);
        else begin
          ea = 12'(q.pop_front());
          chk("addr", addr, ea);
          chk("data", dat[11:0], pat(ea));
          chk("hb_bit", dat[12], hb_prev);
          chk("rco_bit", dat[13], rco_ref);
          chk("pad", dat[15:14], 0);
          if (wcnt > 0) chk("wr_gap", k, last_wr + 1);
        end
        wcnt++;
        last_wr = k;
      end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          done_k = k;
          chk("done_time", k, (exp_n == 0) ? 2 : last_wr + 1);
          chk("busy_in_done", busy, 1);
          if (pulse_done) readout = 1'b1;
        end
      end
      if (done_k >= 0 && k == done_k + 1) chk("busy_fall", busy, 0);
      if (done_k >= 0 && k == done_k + 4) break;
      if (pulse_at >= 0 && wcnt == pulse_at && !pulsed) begin
        readout = 1'b1;
        pulsed = 1;
      end
      if (rst_at >= 0 && wcnt == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wr", wr, 0);
        chk("rst_selmain", selm, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        aborted = 1;
        break;
      end
      if (hold_at >= 0 && wcnt == hold_at) hold = 1'b1;
      hb_in = 1'($urandom);
      hb_prev = hb_in;
      rco_in = 1'($urandom);
      if (!hold) rco_ref = rco_in;
    end
    hold = 1'b0;
    if (!aborted) begin
      chk("wr_total", wcnt, exp_n);
      chk("done_cnt", ndone, 1);
      chk("tail_cycles", ntail, pop * nt);
      chk("main_cycles", nmain, pop * NS);
    end
  endtask

  initial begin
    rst = 1'b1; readout = 1'b0; hold = 1'b0; mask = '0; sel = 1'b0;
    hb_in = 1'b0; rco_in = 1'b0; key = '0;
    repeat (3) @(negedge clk);
    chk("rst_a_selmain", ifa.SELMAIN, 0);
    chk("rst_a_seltail", ifa.SELTAIL, 0);
    chk("rst_a_cs", ifa.CS, 0);
    chk("rst_a_s", ifa.S, 0);
    chk("rst_a_wr", ifa.wr_o, 0);
    chk("rst_a_addr", ifa.addr_o, 0);
    chk("rst_a_busy", busy_a, 0);
    chk("rst_a_done", done_a, 0);
    chk("rst_b_wr", ifb.wr_o, 0);
    chk("rst_b_selmain", ifb.SELMAIN, 0);
    chk("rst_b_busy", busy_b, 0);
    chk("rst_b_addr", ifb.addr_o, 0);
    rst = 1'b0;
    @(negedge clk);
    run(1'b0, 9'h1FF, -1, -1, 1'b0, -1);
    run(1'b0, 9'h005, -1, -1, 1'b0, -1);
    run(1'b0, 9'h000, -1, -1, 1'b0, -1);
    run(1'b0, 9'h1FF, -1, 100, 1'b1, -1);
    run(1'b0, 9'h1FF, 1000, -1, 1'b0, -1);
    run(1'b0, 9'h1FF, -1, -1, 1'b0, -1);
    run(1'b1, 9'h00F, -1, -1, 1'b0, 300);
    for (int i = 0; i < 3; i++) begin
      run(1'b0, 9'($urandom), -1, -1, 1'b0, -1);
      run(1'b1, {5'b0, 4'($urandom)}, -1, -1, 1'b0, 50);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
